// File: rtl/core_muldiv_if.sv
// Request/response bundle between the execute stage and core_muldiv.
// The execute stage drives the master side; the unit is the slave.
interface core_muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, in_valid, op, op1, op2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, op, op1, op2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/core_muldiv.sv
// Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Both operation classes iterate on operand magnitudes, one bit per BUSY
// cycle, sharing a single 2*XLEN accumulator; the sign fix is applied when the
// final iteration writes the result register. Divide-by-zero and signed
// overflow are resolved at acceptance and skip the BUSY phase.
module core_muldiv #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    core_muldiv_if.slave bus
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q,  state_d;
    logic [2:0]        op_q,     op_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;     // multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}
    logic [XLEN-1:0]   opb_q,    opb_d;     // multiplicand or divisor magnitude
    logic              neg_q,    neg_d;     // result needs two's-complement negation
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ---------------- request decode (used only at acceptance) ----------------
    op_e             op_in;
    logic            is_div_in;
    logic            sgn1_in, sgn2_in;
    logic            neg1_in, neg2_in;
    logic            res_neg_in;
    logic [XLEN-1:0] mag1_in, mag2_in;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic            accept;

    assign op_in     = op_e'(bus.op);
    assign is_div_in = bus.op[2];
    assign sgn1_in   = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign sgn2_in   = op_in inside {OP_MULH, OP_DIV, OP_REM};
    assign neg1_in   = sgn1_in & bus.op1[XLEN-1];
    assign neg2_in   = sgn2_in & bus.op2[XLEN-1];
    assign mag1_in   = neg1_in ? -bus.op1 : bus.op1;
    assign mag2_in   = neg2_in ? -bus.op2 : bus.op2;

    // The remainder takes the dividend's sign; products and quotients take the XOR.
    assign res_neg_in = (op_in == OP_REM) ? neg1_in : (neg1_in ^ neg2_in);

    assign div_zero = is_div_in && (bus.op2 == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM))
                   && (bus.op1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.op2 == '1);

    // op[1] selects the remainder flavour of the divide ops.
    assign special_res = div_zero ? (bus.op[1] ? bus.op1 : '1)
                                  : (bus.op[1] ? '0      : bus.op1);

    assign bus.in_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // ---------------- one iteration of each algorithm ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   fin_res;

    // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and trial-subtract.
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign rem_diff = rem_sh - {1'b0, opb_q};
    assign div_ge   = !rem_diff[XLEN];
    assign rem_new  = div_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign div_next = {rem_new, acc_q[XLEN-2:0], div_ge};

    assign step_next = op_q[2] ? div_next : mul_next;

    // The high half of a signed product needs the full-width negation, not a per-half one.
    assign prod_fix = neg_q ? -mul_next : mul_next;
    assign div_val  = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign fin_res  = !op_q[2] ? ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN])
                               : (neg_q ? -div_val : div_val);

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    // NOTE: every *_d gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = bus.op;
                    neg_d = res_neg_in;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                        if (is_div_in) begin
                            acc_d = {{XLEN{1'b0}}, mag1_in};
                            opb_d = mag2_in;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, mag2_in};
                            opb_d = mag1_in;
                        end
                    end
                end
            end
            BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = fin_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything, including a consumer accepting in DONE.
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset clears everything to zero.
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
endmodule
